hdmi_timing_ctrl: RTL and testbench

Programmable video timing sequencer for the HDMI front end. It replaces the compile-time timing constants with run-time registers and generates the registered de/hsync/vsync and pixel coordinates consumed by the pattern generator and the three TMDS encoders. New timing sets are staged in shadow registers, validated, and committed only on a frame boundary, so the sink never sees a torn frame. Start and stop are sequenced so that output always ends on a complete frame.

---
 rtl/hdmi_timing_ctrl_if.sv | 31 +++
 rtl/hdmi_timing_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hdmi_timing_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_ctrl_if.sv
// Configuration and video-timing bundle between the HDMI timing sequencer and its users.
// The sequencer sits on the slave side; the controller/consumer sits on the master side.
interface hdmi_timing_ctrl_if #(
    parameter int CW = 11
);
    logic          enable;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_wdata;
    logic          cfg_apply;
    logic          cfg_pending;
    logic          cfg_err;
    logic          running;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          frame_start;
    logic          line_start;

    modport master (
        output enable, cfg_we, cfg_addr, cfg_wdata, cfg_apply,
        input  cfg_pending, cfg_err, running, de, hsync, vsync, x, y, frame_start, line_start
    );

    modport slave (
        input  enable, cfg_we, cfg_addr, cfg_wdata, cfg_apply,
        output cfg_pending, cfg_err, running, de, hsync, vsync, x, y, frame_start, line_start
    );
endinterface

// File: rtl/hdmi_timing_ctrl.sv
// Run-time programmable video timing sequencer: shadow/active timing sets with
// frame-boundary commit, and a run/drain state machine that always ends on a whole frame.
module hdmi_timing_ctrl #(
    parameter int CW         = 11,
    parameter int RST_HCYCLE = 1024,
    parameter int RST_HSIZE  = 800,
    parameter int RST_HPORCH = 24,
    parameter int RST_HPULSE = 72,
    parameter int RST_VCYCLE = 625,
    parameter int RST_VSIZE  = 600,
    parameter int RST_VPORCH = 1,
    parameter int RST_VPULSE = 2
) (
    input  logic              pixclk,
    input  logic              rst,
    hdmi_timing_ctrl_if.slave bus
);
    localparam int W2 = CW + 2;
    localparam int IX_HCYCLE = 0;
    localparam int IX_HSIZE  = 1;
    localparam int IX_HPORCH = 2;
    localparam int IX_HPULSE = 3;
    localparam int IX_VCYCLE = 4;
    localparam int IX_VSIZE  = 5;
    localparam int IX_VPORCH = 6;
    localparam int IX_VPULSE = 7;

    typedef logic [7:0][CW-1:0] tset_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam tset_t RST_SET = {CW'(RST_VPULSE), CW'(RST_VPORCH), CW'(RST_VSIZE), CW'(RST_VCYCLE),
                                 CW'(RST_HPULSE), CW'(RST_HPORCH), CW'(RST_HSIZE), CW'(RST_HCYCLE)};
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state_q, state_d;
    tset_t         shadow_q, shadow_d, snap_q, snap_d, act_q, act_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d, x_q, x_d, y_q, y_d;
    logic          pending_q, pending_d, err_q, err_d, running_q, running_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, ls_q, ls_d;

    logic [W2-1:0] sh_hsum, sh_vsum, hs_start, hs_end, vs_start, vs_end;
    logic          shadow_ok, line_end, frame_end, active, commit;

    // Sums are widened by two bits so porch/pulse additions can never wrap.
    function automatic logic [W2-1:0] ext(input logic [CW-1:0] v);
        return {2'b00, v};
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        if (bus.cfg_we) shadow_d[bus.cfg_addr] = bus.cfg_wdata;

        sh_hsum   = ext(shadow_q[IX_HSIZE]) + ext(shadow_q[IX_HPORCH]) + ext(shadow_q[IX_HPULSE]);
        sh_vsum   = ext(shadow_q[IX_VSIZE]) + ext(shadow_q[IX_VPORCH]) + ext(shadow_q[IX_VPULSE]);
        shadow_ok = (shadow_q[IX_HSIZE] != '0) && (shadow_q[IX_VSIZE] != '0) &&
                    (shadow_q[IX_HPULSE] != '0) && (shadow_q[IX_VPULSE] != '0) &&
                    (sh_hsum <= ext(shadow_q[IX_HCYCLE])) && (sh_vsum <= ext(shadow_q[IX_VCYCLE]));

        hs_start  = ext(act_q[IX_HSIZE]) + ext(act_q[IX_HPORCH]);
        hs_end    = hs_start + ext(act_q[IX_HPULSE]);
        vs_start  = ext(act_q[IX_VSIZE]) + ext(act_q[IX_VPORCH]);
        vs_end    = vs_start + ext(act_q[IX_VPULSE]);

        line_end  = (cx_q == act_q[IX_HCYCLE] - ONE);
        frame_end = line_end && (cy_q == act_q[IX_VCYCLE] - ONE);
        active    = (state_q != IDLE);
        // While idle nothing is on screen, so the commit need not wait for a frame end.
        commit    = pending_q && (!active || frame_end);

        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = RUN;
            RUN:     if (!bus.enable) state_d = DRAIN;
            DRAIN:   if (bus.enable) state_d = RUN;
                     else if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        running_d = (state_d != IDLE);

        cx_d = '0;
        cy_d = '0;
        if (active) begin
            cx_d = line_end ? '0 : cx_q + ONE;
            cy_d = cy_q;
            if (line_end) cy_d = frame_end ? '0 : cy_q + ONE;
        end

        act_d     = act_q;
        snap_d    = snap_q;
        pending_d = pending_q;
        err_d     = 1'b0;
        if (commit) begin
            act_d     = snap_q;
            pending_d = 1'b0;
        end
        // A new apply wins over a same-cycle commit: the fresh snapshot stays pending.
        if (bus.cfg_apply) begin
            if (shadow_ok) begin
                snap_d    = shadow_q;
                pending_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        de_d = active && (cx_q < act_q[IX_HSIZE]) && (cy_q < act_q[IX_VSIZE]);
        hs_d = active && (ext(cx_q) >= hs_start) && (ext(cx_q) < hs_end);
        vs_d = active && (ext(cy_q) >= vs_start) && (ext(cy_q) < vs_end);
        x_d  = active ? cx_q : '0;
        y_d  = active ? cy_q : '0;
        ls_d = active && (cx_q == '0);
        fs_d = ls_d && (cy_q == '0);
    end

    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= RST_SET;
            snap_q    <= RST_SET;
            act_q     <= RST_SET;
            cx_q      <= '0;
            cy_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fs_q      <= 1'b0;
            ls_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            snap_q    <= snap_d;
            act_q     <= act_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            running_q <= running_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
            ls_q      <= ls_d;
        end
    end

    assign bus.cfg_pending = pending_q;
    assign bus.cfg_err     = err_q;
    assign bus.running     = running_q;
    assign bus.de          = de_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Scoreboard bench for hdmi_timing_ctrl: frame_start and cfg_err events are queued with
// hand-computed cycle stamps and per-frame statistics, and a monitor pops and compares them.
module tb_hdmi_timing_ctrl;
    localparam int CW = 11;

    logic pixclk = 1'b0;
    logic rst    = 1'b1;

    hdmi_timing_ctrl_if #(.CW(CW)) bus ();

    hdmi_timing_ctrl #(.CW(CW)) dut (
        .pixclk (pixclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 pixclk = ~pixclk;

    int cyc = 0;
    always @(posedge pixclk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        bit chk;
        int de;
        int hs;
        int vs;
    } fs_exp_t;

    fs_exp_t fs_q[$];
    int      err_q[$];

    // Timing sets: HCYCLE HSIZE HPORCH HPULSE VCYCLE VSIZE VPORCH VPULSE
    int SET_A[8] = '{40, 20, 4, 6, 12, 8, 1, 2};   // 480-cycle frame
    int SET_B[8] = '{24, 16, 2, 6, 10, 6, 1, 3};   // 240-cycle frame, sums exactly fill both cycles

    // Per-frame statistics: de = HSIZE*VSIZE, hsync = HPULSE*VCYCLE, vsync = VPULSE*HCYCLE
    localparam int A_DE = 160, A_HS = 72, A_VS = 80;
    localparam int B_DE = 96,  B_HS = 60, B_VS = 72;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(negedge pixclk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge pixclk);
    endtask

    task automatic wr(input int a, input int d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'(a);
        bus.cfg_wdata = CW'(d);
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic wr_set(input int s[8]);
        for (int i = 0; i < 8; i++) wr(i, s[i]);
    endtask

    task automatic apply(input bit expect_err);
        if (expect_err) err_q.push_back(cyc + 1);
        bus.cfg_apply = 1'b1;
        tick();
        bus.cfg_apply = 1'b0;
    endtask

    task automatic push_fs(input int c, input bit chk, input int de, input int hs, input int vs);
        fs_exp_t e;
        e.cyc = c; e.chk = chk; e.de = de; e.hs = hs; e.vs = vs;
        fs_q.push_back(e);
    endtask

    // Samples the first ~1100 cycles of a default-timing frame starting at cycle fsc.
    task automatic measure_default(input int fsc);
        int hs_x = -1, hs_w = 0, de_n = 0, vs_n = 0, ls2 = -1, ls2y = -1;
        check("dflt_fs_x", bus.x, 0);
        check("dflt_fs_y", bus.y, 0);
        for (int i = 0; i < 1100; i++) begin
            if (bus.hsync && hs_x < 0) hs_x = int'(bus.x);
            if (bus.hsync && bus.y == '0) hs_w++;
            if (bus.de && bus.y == '0) de_n++;
            if (bus.vsync) vs_n++;
            if (bus.line_start && i > 0 && ls2 < 0) begin
                ls2  = cyc - fsc;
                ls2y = int'(bus.y);
            end
            tick();
        end
        check("dflt_hsync_x", hs_x, 824);
        check("dflt_hsync_width", hs_w, 72);
        check("dflt_de_per_line", de_n, 800);
        check("dflt_vsync_line0", vs_n, 0);
        check("dflt_line_period", ls2, 1024);
        check("dflt_line2_y", ls2y, 1);
    endtask

    // Monitor: compares every frame_start / cfg_err the DUT presents against the queues.
    initial begin
        int mon_de = 0, mon_hs = 0, mon_vs = 0;
        fs_exp_t e;
        int ec;
        forever begin
            @(negedge pixclk);
            if (!rst) begin
                if (bus.frame_start) begin
                    if (fs_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL fs_unexpected: frame_start at cycle %0d, none expected", cyc);
                    end else begin
                        e = fs_q.pop_front();
                        check("fs_cycle", cyc, e.cyc);
                        if (e.chk) begin
                            check("frame_de_count", mon_de, e.de);
                            check("frame_hsync_count", mon_hs, e.hs);
                            check("frame_vsync_count", mon_vs, e.vs);
                        end
                    end
                    mon_de = int'(bus.de);
                    mon_hs = int'(bus.hsync);
                    mon_vs = int'(bus.vsync);
                end else begin
                    mon_de += int'(bus.de);
                    mon_hs += int'(bus.hsync);
                    mon_vs += int'(bus.vsync);
                end
                if (bus.cfg_err) begin
                    if (err_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL err_unexpected: cfg_err at cycle %0d, none expected", cyc);
                    end else begin
                        ec = err_q.pop_front();
                        check("err_cycle", cyc, ec);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, fs0, fs2, fs3, fe, r;
        bus.enable    = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.cfg_apply = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_video", {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.line_start}, 0);
        check("rst_xy", {bus.x, bus.y}, 0);
        check("rst_running", bus.running, 0);
        check("rst_pending", bus.cfg_pending, 0);
        check("rst_err", bus.cfg_err, 0);
        rst = 1'b0;
        tick();

        // Default 800x600 timing
        k = cyc;
        bus.enable = 1'b1;
        push_fs(k + 2, 1'b0, 0, 0, 0);
        wait_cyc(k + 2);
        measure_default(k + 2);

        // Pending apply discarded by reset mid-frame
        wr_set(SET_A);
        apply(1'b0);
        check("pending_before_rst", bus.cfg_pending, 1);
        check("running_before_rst", bus.running, 1);
        for (int i = 0; i < 2000 && !bus.de; i++) tick();
        check("de_before_rst", bus.de, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_video", {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.line_start}, 0);
        check("rst_mid_x", bus.x, 0);
        check("rst_mid_pending", bus.cfg_pending, 0);
        check("rst_mid_running", bus.running, 0);
        bus.enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Defaults restored after reset
        k = cyc;
        bus.enable = 1'b1;
        push_fs(k + 2, 1'b0, 0, 0, 0);
        wait_cyc(k + 2);
        measure_default(k + 2);
        #1 rst = 1'b1;
        tick();
        bus.enable = 1'b0;
        rst = 1'b0;
        tick();

        // Commit in IDLE takes effect the cycle after the apply
        wr_set(SET_A);
        apply(1'b0);
        check("idle_apply_pending", bus.cfg_pending, 1);
        tick();
        check("idle_commit_pending", bus.cfg_pending, 0);

        k = cyc;
        bus.enable = 1'b1;
        fs0 = k + 2;
        push_fs(fs0, 1'b0, 0, 0, 0);
        push_fs(fs0 + 480, 1'b1, A_DE, A_HS, A_VS);
        push_fs(fs0 + 960, 1'b1, A_DE, A_HS, A_VS);

        // Invalid sets: sum overflows HCYCLE, then HPULSE of zero
        wait_cyc(fs0 + 50);
        wr(0, 1024); wr(1, 900); wr(2, 24); wr(3, 128);
        apply(1'b1);
        check("bad_sum_pending", bus.cfg_pending, 0);
        wr(1, 20); wr(3, 0);
        apply(1'b1);
        check("bad_pulse_pending", bus.cfg_pending, 0);

        // Mid-frame apply waits for the frame end; later shadow writes do not leak in
        wait_cyc(fs0 + 580);
        wr_set(SET_B);
        apply(1'b0);
        check("mid_apply_pending", bus.cfg_pending, 1);
        wr(0, 7);
        fs2 = fs0 + 960;
        wait_cyc(fs2 - 2);
        check("pending_until_frame_end", bus.cfg_pending, 1);
        tick();
        check("pending_clear_at_commit", bus.cfg_pending, 0);
        push_fs(fs2 + 240, 1'b1, B_DE, B_HS, B_VS);
        push_fs(fs2 + 480, 1'b1, B_DE, B_HS, B_VS);

        // Short enable drop: no restart, spacing unchanged
        wait_cyc(fs2 + 290);
        bus.enable = 1'b0;
        repeat (10) tick();
        check("glitch_running", bus.running, 1);
        bus.enable = 1'b1;
        fs3 = fs2 + 720;
        push_fs(fs3, 1'b1, B_DE, B_HS, B_VS);

        // Drain to the frame end, then idle
        wait_cyc(fs3 + 100);
        bus.enable = 1'b0;
        fe = fs3 + 240;
        wait_cyc(fe - 2);
        check("drain_running", bus.running, 1);
        tick();
        check("drain_idle_running", bus.running, 0);
        check("drain_last_x", bus.x, 23);
        check("drain_last_y", bus.y, 9);
        check("drain_last_hsync", bus.hsync, 1);
        tick();
        check("idle_video", {bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.line_start}, 0);
        check("idle_xy", {bus.x, bus.y}, 0);

        // Re-enable: frame_start on the cycle after next
        wait_cyc(fe + 20);
        r = cyc;
        bus.enable = 1'b1;
        push_fs(r + 2, 1'b1, B_DE, B_HS, B_VS);
        push_fs(r + 242, 1'b1, B_DE, B_HS, B_VS);
        wait_cyc(r + 260);

        check("fs_queue_drained", fs_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
